// File: rtl/snes_region_pkg.sv
// Shared mode/state encodings and decode helpers for the SNES reset-button
// region controller.
package snes_region_pkg;

    typedef enum logic [1:0] {
        MODE_NTSC = 2'b00,
        MODE_PAL  = 2'b01,
        MODE_PALP = 2'b10,
        MODE_BAD  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_PRESSED = 3'd2,
        ST_SELECT  = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

    // LED patterns are {red, green}
    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_NTSC = 2'b01;
    localparam logic [1:0] LED_PAL  = 2'b10;
    localparam logic [1:0] LED_PALP = 2'b11;

    localparam int MS_W = 11;

    function automatic mode_t mode_sanitize(input logic [1:0] raw);
        mode_t m;
        m = (raw == 2'b11) ? MODE_NTSC : mode_t'(raw);
        return m;
    endfunction

    function automatic mode_t mode_next(input mode_t m);
        mode_t n;
        case (m)
            MODE_NTSC: n = MODE_PAL;
            MODE_PAL:  n = MODE_PALP;
            default:   n = MODE_NTSC;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] mode_led(input mode_t m);
        logic [1:0] l;
        case (m)
            MODE_PAL:  l = LED_PAL;
            MODE_PALP: l = LED_PALP;
            default:   l = LED_NTSC;
        endcase
        return l;
    endfunction

    function automatic logic mode_pal(input mode_t m);
        return (m == MODE_PAL) || (m == MODE_PALP);
    endfunction

    function automatic logic mode_patch(input mode_t m);
        return (m == MODE_PALP);
    endfunction

endpackage

// File: rtl/snes_btn_debounce.sv
// Millisecond tick generator plus synchronizer and debouncer for the
// active-low console reset button; btn is 1 while the button is pressed.
module snes_btn_debounce #(
    parameter int TICK_DIV = 21477,
    parameter int DEB_MS   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic nrst_btn,
    output logic tick,
    output logic btn
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       sync;
    logic [DEB_W-1:0] deb_cnt;

    assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], ~nrst_btn};
        end
    end

    // Any sample that agrees with btn restarts the stability window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt <= '0;
            btn     <= 1'b0;
        end else if (sync[1] == btn) begin
            deb_cnt <= '0;
        end else if (tick) begin
            if (deb_cnt == DEB_W'(DEB_MS - 1)) begin
                btn     <= sync[1];
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snes_region_ctrl.sv
// Reset-button region controller: short press resets the console, long press
// cycles the region mode, and the committed mode is decoded for snes_mult_func.
module snes_region_ctrl
    import snes_region_pkg::*;
#(
    parameter int TICK_DIV    = 21477,
    parameter int DEB_MS      = 16,
    parameter int LONG_MS     = 750,
    parameter int CYCLE_MS    = 1000,
    parameter int RST_HOLD_MS = 200
) (
    input  logic       MCLK_i,
    input  logic       RST_i,
    input  logic       NRST_BTN_i,
    input  logic [1:0] DEFAULT_MODE_i,
    output logic       NRST_CONSOLE_o,
    output logic [1:0] MODE_o,
    output logic       PALMODE_o,
    output logic       EN_REGPATCH_o,
    output logic [1:0] LED_o
);

    logic            tick;
    logic            btn;
    logic            btn_q;
    state_t          state;
    logic            boot_load;
    mode_t           mode;
    mode_t           cand;
    logic [MS_W-1:0] ms;
    logic [MS_W-1:0] ms_step;
    logic [7:0]      free_ms;

    snes_btn_debounce #(
        .TICK_DIV (TICK_DIV),
        .DEB_MS   (DEB_MS)
    ) u_deb (
        .clk      (MCLK_i),
        .rst      (RST_i),
        .nrst_btn (NRST_BTN_i),
        .tick     (tick),
        .btn      (btn)
    );

    assign ms_step = (tick && (ms != '1)) ? ms + 1'b1 : ms;

    // Free-running blink timebase; bit 7 gives roughly 4 Hz
    always_ff @(posedge MCLK_i or posedge RST_i) begin
        if (RST_i) begin
            free_ms <= '0;
        end else if (tick) begin
            free_ms <= free_ms + 1'b1;
        end
    end

    always_ff @(posedge MCLK_i or posedge RST_i) begin
        if (RST_i) begin
            state          <= ST_BOOT;
            boot_load      <= 1'b1;
            mode           <= MODE_NTSC;
            cand           <= MODE_NTSC;
            ms             <= '0;
            btn_q          <= 1'b0;
            NRST_CONSOLE_o <= 1'b0;
            MODE_o         <= 2'b00;
            PALMODE_o      <= 1'b0;
            EN_REGPATCH_o  <= 1'b0;
            LED_o          <= LED_OFF;
        end else begin
            btn_q         <= btn;
            ms            <= ms_step;
            MODE_o        <= mode;
            PALMODE_o     <= mode_pal(mode);
            EN_REGPATCH_o <= mode_patch(mode);
            // LEDs stay dark until the power-up mode has actually been loaded
            if (boot_load) begin
                LED_o <= LED_OFF;
            end else if (state == ST_SELECT) begin
                LED_o <= free_ms[7] ? LED_OFF : mode_led(cand);
            end else begin
                LED_o <= mode_led(mode);
            end

            case (state)
                ST_BOOT: begin
                    NRST_CONSOLE_o <= 1'b0;
                    if (boot_load) begin
                        boot_load <= 1'b0;
                        mode      <= mode_sanitize(DEFAULT_MODE_i);
                        ms        <= '0;
                    end else if (ms >= MS_W'(RST_HOLD_MS)) begin
                        state          <= ST_IDLE;
                        NRST_CONSOLE_o <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    NRST_CONSOLE_o <= 1'b1;
                    if (btn && !btn_q) begin
                        state          <= ST_PRESSED;
                        NRST_CONSOLE_o <= 1'b0;
                        ms             <= '0;
                    end
                end
                ST_PRESSED: begin
                    // Release is checked first so a tie counts as a short press
                    if (!btn) begin
                        state          <= ST_IDLE;
                        NRST_CONSOLE_o <= 1'b1;
                    end else if (ms >= MS_W'(LONG_MS)) begin
                        state <= ST_SELECT;
                        cand  <= mode_next(mode);
                        ms    <= '0;
                    end
                end
                ST_SELECT: begin
                    if (!btn) begin
                        state <= ST_COMMIT;
                        mode  <= cand;
                        ms    <= '0;
                    end else if (ms >= MS_W'(CYCLE_MS)) begin
                        cand <= mode_next(cand);
                        ms   <= '0;
                    end
                end
                ST_COMMIT: begin
                    if (ms >= MS_W'(RST_HOLD_MS)) begin
                        state          <= ST_IDLE;
                        NRST_CONSOLE_o <= 1'b1;
                    end
                end
                default: begin
                    state          <= ST_BOOT;
                    boot_load      <= 1'b1;
                    NRST_CONSOLE_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snes_region_ctrl.sv
// Bench for snes_region_ctrl with small timing parameters: press-length table,
// bounce rejection, reset during select, and mode stability while running.
module tb_snes_region_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int DEB_MS      = 2;
    localparam int LONG_MS     = 10;
    localparam int CYCLE_MS    = 8;
    localparam int RST_HOLD_MS = 5;

    logic       MCLK_i = 1'b0;
    logic       RST_i = 1'b1;
    logic       NRST_BTN_i = 1'b1;
    logic [1:0] DEFAULT_MODE_i = 2'b00;
    logic       NRST_CONSOLE_o;
    logic [1:0] MODE_o;
    logic       PALMODE_o;
    logic       EN_REGPATCH_o;
    logic [1:0] LED_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] def_mode;
        int         hold;
        logic [1:0] exp_mode;
    } vec_t;

    typedef struct {
        logic [1:0] mode;
        logic       pal;
        logic       patch;
        logic [1:0] led;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    snes_region_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .DEB_MS      (DEB_MS),
        .LONG_MS     (LONG_MS),
        .CYCLE_MS    (CYCLE_MS),
        .RST_HOLD_MS (RST_HOLD_MS)
    ) dut (
        .MCLK_i         (MCLK_i),
        .RST_i          (RST_i),
        .NRST_BTN_i     (NRST_BTN_i),
        .DEFAULT_MODE_i (DEFAULT_MODE_i),
        .NRST_CONSOLE_o (NRST_CONSOLE_o),
        .MODE_o         (MODE_o),
        .PALMODE_o      (PALMODE_o),
        .EN_REGPATCH_o  (EN_REGPATCH_o),
        .LED_o          (LED_o)
    );

    always #5 MCLK_i = ~MCLK_i;

    function automatic exp_t exp_of(input logic [1:0] m);
        exp_t e;
        e.mode = m;
        case (m)
            2'b01:   begin e.pal = 1'b1; e.patch = 1'b0; e.led = 2'b10; end
            2'b10:   begin e.pal = 1'b1; e.patch = 1'b1; e.led = 2'b11; end
            default: begin e.mode = 2'b00; e.pal = 1'b0; e.patch = 1'b0; e.led = 2'b01; end
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic wait_nrst(output int cyc, input int start);
        cyc = start;
        while (!NRST_CONSOLE_o && cyc < 400) begin
            @(negedge MCLK_i);
            cyc++;
        end
    endtask

    task automatic check_sb(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=empty_queue required=entry", name);
        end else begin
            e = sb.pop_front();
            check(name, {26'd0, MODE_o, PALMODE_o, EN_REGPATCH_o, LED_o},
                  {26'd0, e.mode, e.pal, e.patch, e.led});
        end
    endtask

    task automatic do_reset(input logic [1:0] def);
        int   cyc;
        exp_t e;
        RST_i = 1'b1;
        NRST_BTN_i = 1'b1;
        DEFAULT_MODE_i = def;
        repeat (3) @(negedge MCLK_i);
        check("reset_state", {25'd0, NRST_CONSOLE_o, MODE_o, PALMODE_o, EN_REGPATCH_o, LED_o}, 32'd0);
        RST_i = 1'b0;
        e = exp_of(def);
        sb.push_back(e);
        @(negedge MCLK_i);
        check("release_cycle", {25'd0, NRST_CONSOLE_o, MODE_o, PALMODE_o, EN_REGPATCH_o, LED_o}, 32'd0);
        @(negedge MCLK_i);
        check("boot_decode", {27'd0, NRST_CONSOLE_o, MODE_o, PALMODE_o, EN_REGPATCH_o},
              {27'd0, 1'b0, e.mode, e.pal, e.patch});
        wait_nrst(cyc, 2);
        check_range("boot_hold_cycles", cyc, 18, 26);
        check_sb("boot_outputs");
    endtask

    // Mode decode must never move while the console is running
    logic       prev_nrst = 1'b0;
    logic [3:0] prev_dec = 4'd0;
    always @(negedge MCLK_i) begin
        if (NRST_CONSOLE_o && prev_nrst) begin
            checks++;
            if ({MODE_o, PALMODE_o, EN_REGPATCH_o} !== prev_dec) begin
                errors++;
                $display("FAIL run_stability actual=%0h required=%0h",
                         {MODE_o, PALMODE_o, EN_REGPATCH_o}, prev_dec);
            end
        end
        prev_nrst = NRST_CONSOLE_o;
        prev_dec  = {MODE_o, PALMODE_o, EN_REGPATCH_o};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        vecs[0] = '{def_mode: 2'b01, hold: 6,  exp_mode: 2'b01};
        vecs[1] = '{def_mode: 2'b00, hold: 6,  exp_mode: 2'b00};
        vecs[2] = '{def_mode: 2'b00, hold: 14, exp_mode: 2'b01};
        vecs[3] = '{def_mode: 2'b01, hold: 30, exp_mode: 2'b01};
        vecs[4] = '{def_mode: 2'b00, hold: 22, exp_mode: 2'b10};
        vecs[5] = '{def_mode: 2'b10, hold: 38, exp_mode: 2'b00};
        vecs[6] = '{def_mode: 2'b11, hold: 14, exp_mode: 2'b01};
        vecs[7] = '{def_mode: 2'b10, hold: 14, exp_mode: 2'b00};

        for (int i = 0; i < 8; i++) begin
            do_reset(vecs[i].def_mode);
            repeat (8) @(negedge MCLK_i);
            NRST_BTN_i = 1'b0;
            repeat (4 * TICK_DIV) @(negedge MCLK_i);
            check("held_reset_low", {31'd0, NRST_CONSOLE_o}, 32'd0);
            repeat ((vecs[i].hold - 4) * TICK_DIV) @(negedge MCLK_i);
            NRST_BTN_i = 1'b1;
            sb.push_back(exp_of(vecs[i].exp_mode));
            wait_nrst(cyc, 0);
            if (vecs[i].hold < LONG_MS)
                check_range("short_release_cycles", cyc, 4, 16);
            else
                check_range("commit_release_cycles", cyc, 24, 36);
            check_sb("final_outputs");
            repeat (10) @(negedge MCLK_i);
        end

        // 3-cycle glitches never span two ticks, so btn must not move
        do_reset(2'b00);
        repeat (8) @(negedge MCLK_i);
        for (int g = 0; g < 6; g++) begin
            NRST_BTN_i = 1'b0;
            repeat (3) @(negedge MCLK_i);
            NRST_BTN_i = 1'b1;
            repeat (5) @(negedge MCLK_i);
            check("bounce_nrst", {31'd0, NRST_CONSOLE_o}, 32'd1);
        end
        repeat (12) @(negedge MCLK_i);
        check("bounce_after", {29'd0, NRST_CONSOLE_o, MODE_o}, {29'd0, 1'b1, 2'b00});

        // Reset while in SELECT with cand = 10
        do_reset(2'b01);
        repeat (8) @(negedge MCLK_i);
        NRST_BTN_i = 1'b0;
        repeat (15 * TICK_DIV) @(negedge MCLK_i);
        check("select_led", {30'd0, LED_o}, {30'd0, 2'b11});
        check("select_state", {29'd0, NRST_CONSOLE_o, MODE_o}, {29'd0, 1'b0, 2'b01});
        RST_i = 1'b1;
        @(negedge MCLK_i);
        check("mid_select_reset", {25'd0, NRST_CONSOLE_o, MODE_o, PALMODE_o, EN_REGPATCH_o, LED_o}, 32'd0);
        do_reset(2'b01);
        repeat (4) @(negedge MCLK_i);
        check("reload_default", {30'd0, MODE_o}, {30'd0, 2'b01});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
